// File: rtl/iir_seq_ctrl.sv
// Sequencer in front of an IIR core: buffers samples in a 4-deep FIFO, flushes the
// core on start, issues one sample per RATE_DIV cycles and captures each result.
module iir_seq_ctrl #(
   parameter int unsigned RATE_DIV  = 4,
   parameter int unsigned FLUSH_CYC = 5
) (
   input  logic        clk_21,
   input  logic        rst_n_21,
   input  logic        start_21,
   input  logic        stop_21,
   input  logic        in_valid_21,
   input  logic [7:0]  in_data_21,
   output logic        in_ready_21,
   output logic [7:0]  core_din_21,
   output logic        core_data_valid_21,
   output logic        core_rst_21,
   input  logic [19:0] core_dout_21,
   output logic [19:0] dout_21,
   output logic        dout_valid_21,
   output logic        busy_21,
   output logic [7:0]  underrun_cnt_21
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t      state, state_nx;

   logic [7:0]  fifo_mem [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  fifo_cnt;
   logic        fifo_full, fifo_empty;
   logic        push, pop;

   logic [7:0]  div_cnt, div_nx;
   logic [7:0]  flush_cnt, flush_nx;
   logic        drain_cnt, drain_nx;
   logic        tick;
   logic        underrun_inc, clr_underrun;
   logic        cap_pend;

   assign fifo_full   = (fifo_cnt == 3'd4);
   assign fifo_empty  = (fifo_cnt == 3'd0);
   assign in_ready_21 = ~fifo_full;
   assign push        = in_valid_21 & ~fifo_full;

   always_comb begin
      state_nx     = state;
      div_nx       = '0;
      flush_nx     = flush_cnt;
      drain_nx     = drain_cnt;
      tick         = 1'b0;
      pop          = 1'b0;
      underrun_inc = 1'b0;
      clr_underrun = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_21) begin
               state_nx     = S_FLUSH;
               flush_nx     = '0;
               clr_underrun = 1'b1;
            end
         end
         S_FLUSH: begin
            if (flush_cnt == 8'(FLUSH_CYC - 1)) begin
               state_nx = S_RUN;
            end else begin
               flush_nx = flush_cnt + 8'd1;
            end
         end
         S_RUN: begin
            tick   = (div_cnt == '0);
            div_nx = (div_cnt == 8'(RATE_DIV - 1)) ? '0 : div_cnt + 8'd1;
            // stop takes priority over a coinciding tick: nothing popped or counted
            if (stop_21) begin
               state_nx = S_DRAIN;
               drain_nx = 1'b0;
            end else if (tick) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  underrun_inc = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt) begin
               state_nx = S_IDLE;
            end else begin
               drain_nx = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_21) begin
      if (!rst_n_21) begin
         state              <= S_IDLE;
         div_cnt            <= '0;
         flush_cnt          <= '0;
         drain_cnt          <= 1'b0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         fifo_cnt           <= '0;
         core_din_21        <= '0;
         core_data_valid_21 <= 1'b0;
         core_rst_21        <= 1'b0;
         cap_pend           <= 1'b0;
         dout_21            <= '0;
         dout_valid_21      <= 1'b0;
         busy_21            <= 1'b0;
         underrun_cnt_21    <= '0;
      end else begin
         state     <= state_nx;
         div_cnt   <= div_nx;
         flush_cnt <= flush_nx;
         drain_cnt <= drain_nx;

         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);

         core_data_valid_21 <= pop;
         if (pop) begin
            core_din_21 <= fifo_mem[rd_ptr];
         end
         core_rst_21 <= (state_nx == S_FLUSH);
         busy_21     <= (state_nx != S_IDLE);

         // core result for an issued sample is ready one cycle after the issue cycle
         cap_pend      <= core_data_valid_21;
         dout_valid_21 <= cap_pend;
         if (cap_pend) begin
            dout_21 <= core_dout_21;
         end

         if (clr_underrun) begin
            underrun_cnt_21 <= '0;
         end else if (underrun_inc && (underrun_cnt_21 != '1)) begin
            underrun_cnt_21 <= underrun_cnt_21 + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_21) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data_21;
      end
   end

endmodule

// File: doc/iir_seq_ctrl.md
IIR_SEQ_CTRL -- requirements
Module: iir_seq_ctrl

Interface
REQ-001 Parameter RATE_DIV, default 4, cycles between sample-issue opportunities in RUN (legal 1..255).
REQ-002 Parameter FLUSH_CYC, default 5, cycles core reset is held in FLUSH (5 clears in1..in3 and y1,y2).
REQ-003 clk_21  input  1  single clock; all logic on rising edge.
REQ-004 rst_n_21  input  1  synchronous active-low reset.
REQ-005 start_21  input  1  one-cycle request to begin a run.
REQ-006 stop_21  input  1  one-cycle request to end a run.
REQ-007 in_valid_21  input  1  upstream sample valid.
REQ-008 in_data_21  input  8  upstream sample.
REQ-009 in_ready_21  output  1  FIFO can accept; equals not-full.
REQ-010 core_din_21  output  8  sample to IIR core, registered.
REQ-011 core_data_valid_21  output  1  data-valid to IIR core, registered.
REQ-012 core_rst_21  output  1  active-high reset to IIR core, registered.
REQ-013 core_dout_21  input  20  IIR core result.
REQ-014 dout_21  output  20  captured filter result.
REQ-015 dout_valid_21  output  1  one-cycle strobe, dout_21 new.
REQ-016 busy_21  output  1  high in FLUSH, RUN, DRAIN.
REQ-017 underrun_cnt_21  output  8  saturating count of issue ticks with empty FIFO.

Function
REQ-018 Input FIFO SHALL be 4 entries x 8 bits; push when in_valid_21 & in_ready_21; no fall-through (push into empty FIFO not poppable same cycle); push is ignored (never occurs) when full.
REQ-019 FIFO SHALL accept pushes in every state including IDLE; contents persist across runs; simultaneous push and pop with 1..3 entries SHALL keep count unchanged.
REQ-020 FSM states IDLE, FLUSH, RUN, DRAIN; IDLE->FLUSH on start_21; start_21 outside IDLE ignored.
REQ-021 FLUSH SHALL drive core_rst_21=1, core_data_valid_21=0 for exactly FLUSH_CYC cycles, then enter RUN; stop_21 during FLUSH ignored.
REQ-022 In RUN a divider counter SHALL start at 0 on entry, wrap RATE_DIV-1 -> 0; tick when counter==0 (first tick in first RUN cycle).
REQ-023 On tick with FIFO non-empty: pop head, next cycle core_din_21=head, core_data_valid_21=1 (issue cycle).
REQ-024 On tick with FIFO empty: no pop, core_data_valid_21 stays 0, underrun_cnt_21 increments, saturating at 255.
REQ-025 Outside issue cycles core_data_valid_21=0, core_din_21 holds last value, core_rst_21=0 (except FLUSH).
REQ-026 Capture: core_dout_21 SHALL be registered into dout_21 at end of the cycle after each issue cycle; dout_valid_21=1 in issue cycle+2, for one cycle; dout_21 holds otherwise.
REQ-027 stop_21 in RUN SHALL enter DRAIN; if stop_21 and tick coincide, stop wins, no pop, no underrun count.
REQ-028 DRAIN SHALL last 2 cycles (completing any pending capture), then IDLE; no pops in DRAIN.
REQ-029 underrun_cnt_21 SHALL clear on IDLE->FLUSH transition.
REQ-030 busy_21 SHALL be registered-consistent with state (high in FLUSH/RUN/DRAIN, low in IDLE).

Reset
REQ-031 While rst_n_21=0 at a clock edge: state IDLE, FIFO empty, divider 0, all outputs 0 (in_ready_21=1 from next cycle), pending capture cancelled.
REQ-032 Reset mid-run SHALL abort immediately; no dout_valid_21 after reset even if an issue was in flight.

Verification
REQ-033 Reset, start, FIFO preloaded 0x10,0x20 -> core_rst_21 high 5 cycles, issues of 0x10 at RUN cycle 1 and 0x20 at RUN cycle 5 (RATE_DIV=4), dout_valid_21 two cycles after each.
REQ-034 Push 5 samples back-to-back in IDLE -> in_ready_21 low after 4th, 5th held until RUN pops; order preserved.
REQ-035 RUN with empty FIFO for 300 ticks -> underrun_cnt_21 saturates at 255; next start clears to 0.
REQ-036 stop_21 on a tick cycle -> no issue, DRAIN 2 cycles, busy_21 low, remaining FIFO entries retained.
REQ-037 Issue then rst_n_21=0 next cycle -> no dout_valid_21, dout_21=0, FIFO empty.
REQ-038 RATE_DIV=1, FIFO full, core model y=15*(in1+in2+in3) plus feedback -> issue every cycle, dout_valid_21 every cycle, dout_21 matches model per sample.
